// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the serial FIR datapath: default sample width and
// tap count, the index-width and beat-count derivations, and the sequencer
// state type. The coefficient ROM and MAC import this package as well.
package fir_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int TAPS_DEF   = 16;

  // Width of a beat index; never narrower than one bit.
  function automatic int calc_idx_w(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

  // Beats per sample: mirrored pairs halve the walk, rounding up so an odd
  // line still visits its centre tap.
  function automatic int calc_beats(input int taps, input int symmetric);
    return (symmetric != 0) ? (taps + 1) / 2 : taps;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/tap_read_mux.sv
// tap_read_mux
// Indexed read of a TAPS-deep delay line. Any select value outside
// 0..TAPS-1 returns zero, which lets callers blank a port simply by
// steering the select out of range.
// Ports:
//   line_i  in   TAPS x DATA_W   delay-line contents, entry 0 is newest
//   sel_i   in   clog2(TAPS+1)   entry to read
//   data_o  out  DATA_W          selected entry, or 0 when out of range
module tap_read_mux
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic [TAPS-1:0][DATA_W-1:0]   line_i,
  input  logic [$clog2(TAPS+1)-1:0]     sel_i,
  output logic [DATA_W-1:0]             data_o
);

  localparam int SEL_W = $clog2(TAPS + 1);

  // Compare against every legal entry so the out-of-range case falls out
  // naturally as the zero default.
  always_comb begin
    data_o = '0;
    for (int j = 0; j < TAPS; j++) begin
      if (sel_i == SEL_W'(j)) begin
        data_o = line_i[j];
      end
    end
  end

endmodule

// File: rtl/sym_tap_sequencer.sv
// sym_tap_sequencer
// Tap delay line plus read sequencer feeding the serial FIR MAC. One sample
// is accepted per handshake and shifted into the line; the block then walks
// the taps on its own, one beat per downstream handshake. In symmetric mode
// each beat carries the mirrored pair (k, TAPS-1-k) so the MAC can pre-add.
// Ports:
//   clk_i        in   1       rising-edge clock
//   rstn_i       in   1       asynchronous active-low reset
//   flush_i      in   1       synchronous clear of line and sequencer
//   s_valid_i    in   1       input sample valid
//   s_ready_o    out  1       block can accept a sample
//   s_data_i     in   DATA_W  input sample
//   tap_valid_o  out  1       tap beat valid
//   tap_ready_i  in   1       downstream accepts the beat
//   tap_idx_o    out  IDX_W   beat index k
//   tap_a_o      out  DATA_W  line[k]
//   tap_b_o      out  DATA_W  line[TAPS-1-k] in pair mode, else 0
//   tap_first_o  out  1       beat k==0
//   tap_last_o   out  1       beat k==BEATS-1
module sym_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int SYMMETRIC = 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         flush_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [DATA_W-1:0]            s_data_i,
  output logic                         tap_valid_o,
  input  logic                         tap_ready_i,
  output logic [calc_idx_w(TAPS)-1:0]  tap_idx_o,
  output logic [DATA_W-1:0]            tap_a_o,
  output logic [DATA_W-1:0]            tap_b_o,
  output logic                         tap_first_o,
  output logic                         tap_last_o
);

  localparam int IDX_W = calc_idx_w(TAPS);
  localparam int BEATS = calc_beats(TAPS, SYMMETRIC);
  localparam int SEL_W = $clog2(TAPS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] CENTRE_IDX = IDX_W'(TAPS / 2);
  localparam bit               HAS_CENTRE = (SYMMETRIC != 0) && (TAPS % 2 == 1);
  localparam logic [SEL_W-1:0] SEL_NONE   = SEL_W'(TAPS);
  localparam logic [SEL_W-1:0] SEL_TOP    = SEL_W'(TAPS - 1);

  seq_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [TAPS-1:0][DATA_W-1:0] line_q;
  logic                        accept;
  logic                        beat;
  logic [SEL_W-1:0]            sel_a, sel_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over both a same-cycle accept and a same-cycle beat.
  always_comb begin
    state_d     = state_q;
    s_ready_o   = 1'b0;
    tap_valid_o = 1'b0;
    accept      = 1'b0;
    beat        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        tap_valid_o = 1'b1;
        if (tap_ready_i) begin
          beat = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // idx wraps back to zero on the final beat so it never exceeds BEATS-1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q <= '0;
    end else if (flush_i || accept) begin
      idx_q <= '0;
    end else if (beat) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The line only moves on an accept, which can only happen in IDLE, so it
  // stays frozen while beats are outstanding.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      line_q <= '0;
    end else if (flush_i) begin
      line_q <= '0;
    end else if (accept) begin
      line_q <= {line_q[TAPS-2:0], s_data_i};
    end
  end

  // Out-of-range selects blank a port: both ports while idle, the B port in
  // single mode and on the centre beat of an odd symmetric line.
  always_comb begin
    sel_a = SEL_NONE;
    sel_b = SEL_NONE;
    if (tap_valid_o) begin
      sel_a = SEL_W'(idx_q);
      if ((SYMMETRIC != 0) && !(HAS_CENTRE && (idx_q == CENTRE_IDX))) begin
        sel_b = SEL_TOP - SEL_W'(idx_q);
      end
    end
  end

  tap_read_mux #(.DATA_W(DATA_W), .TAPS(TAPS)) u_read_a (
    .line_i (line_q),
    .sel_i  (sel_a),
    .data_o (tap_a_o)
  );

  tap_read_mux #(.DATA_W(DATA_W), .TAPS(TAPS)) u_read_b (
    .line_i (line_q),
    .sel_i  (sel_b),
    .data_o (tap_b_o)
  );

  assign tap_idx_o   = tap_valid_o ? idx_q : '0;
  assign tap_first_o = tap_valid_o && (idx_q == '0);
  assign tap_last_o  = tap_valid_o && (idx_q == LAST_IDX);

endmodule
